rob_commit: RTL

In-order retirement unit that drains the reorder buffer head and writes architectural results to the register file. It watches the head-entry busy flags, issues one- or two-entry pop strobes to the reorder buffer, captures the popped entries, and drives two register-file write ports. It sits between the reorder buffer read side and the register file, and is the consumer of the reorder buffer's pop interface.

---
 rtl/rob_pkg.sv | 23 ++
 rtl/rob_commit_slot.sv | 27 ++
 rtl/rob_commit.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/rob_pkg.sv
// Shared definitions for the reorder-buffer retirement path: entry field
// positions, pop-count encodings and the commit FSM state type.
package rob_pkg;

  localparam int ROB_BUSY_BIT = 69;
  localparam int ROB_TAG_HI   = 68;
  localparam int ROB_TAG_LO   = 37;
  localparam int ROB_DEST_HI  = 36;
  localparam int ROB_DEST_LO  = 32;
  localparam int ROB_VAL_HI   = 31;
  localparam int ROB_VAL_LO   = 0;

  localparam logic [1:0] RE_ONE = 2'b00;
  localparam logic [1:0] RE_TWO = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STROBE,
    ST_SETTLE,
    ST_WRITE
  } commit_state_e;

endpackage

// File: rtl/rob_commit_slot.sv
// Combinational per-entry write qualification for one retirement slot:
// splits a popped ROB entry into address, data and tag and decides if it writes.
module rob_commit_slot
  import rob_pkg::*;
#(
  parameter int DATA_WIDTH = 70,
  parameter int TAG_WIDTH  = 32
) (
  input  logic                  active,
  input  logic                  zero_hint,
  input  logic [DATA_WIDTH-1:0] entry,
  output logic                  qual,
  output logic [4:0]            waddr,
  output logic [31:0]           wdata,
  output logic [TAG_WIDTH-1:0]  tag
);

  always_comb begin
    waddr = entry[ROB_DEST_HI:ROB_DEST_LO];
    wdata = entry[ROB_VAL_HI:ROB_VAL_LO];
    tag   = entry[ROB_TAG_HI:ROB_TAG_LO];
    // Squashed entries, still-busy entries and writes to r0 retire silently.
    qual  = active && !zero_hint && (entry != '0) && !entry[ROB_BUSY_BIT]
            && (waddr != 5'd0);
  end

endmodule

// File: rtl/rob_commit.sv
// In-order retirement: pops one or two ROB head entries and writes them to the
// register file. Two-wide retirement is enabled by defining COMMIT_DUAL_EN.
module rob_commit
  import rob_pkg::*;
#(
  parameter int DATA_WIDTH = 70,
  parameter int TAG_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  commit_en,
  input  logic                  flush,
  input  logic                  buf_empty0,
  input  logic                  buf_empty1,
  input  logic                  head_flag0,
  input  logic                  head_flag1,
  input  logic                  head_zero0,
  input  logic                  head_zero1,
  input  logic [DATA_WIDTH-1:0] buf_out0,
  input  logic [DATA_WIDTH-1:0] buf_out1,
  output logic [1:0]            re,
  output logic                  rd_strobe,
  output logic                  rf_we0,
  output logic                  rf_we1,
  output logic [4:0]            rf_waddr0,
  output logic [4:0]            rf_waddr1,
  output logic [31:0]           rf_wdata0,
  output logic [31:0]           rf_wdata1,
  output logic [TAG_WIDTH-1:0]  last_tag,
  output logic [31:0]           retired_cnt
);

  commit_state_e         state_q, state_d;
  logic [1:0]            re_q, re_d;
  logic                  rd_strobe_q, rd_strobe_d;
  logic                  flushed_q, flushed_d;
  logic                  zero0_q, zero0_d;
  logic                  zero1_q, zero1_d;
  logic                  we0_q, we0_d, we1_q, we1_d;
  logic [4:0]            waddr0_q, waddr0_d, waddr1_q, waddr1_d;
  logic [31:0]           wdata0_q, wdata0_d, wdata1_q, wdata1_d;
  logic [TAG_WIDTH-1:0]  last_tag_q, last_tag_d;
  logic [31:0]           cnt_q, cnt_d;

  logic                  pop_one, pop_two;
  logic                  hz1_in;
  logic [DATA_WIDTH-1:0] s1_entry;

  logic                  q0, q1;
  logic [4:0]            a0, a1;
  logic [31:0]           d0, d1;
  logic [TAG_WIDTH-1:0]  t0, t1;

  assign pop_one = !buf_empty0 && !head_flag0;

`ifdef COMMIT_DUAL_EN
  assign pop_two  = !buf_empty1 && !head_flag0 && !head_flag1;
  assign hz1_in   = head_zero1;
  assign s1_entry = buf_out1;
`else
  logic unused_dual;
  assign unused_dual = ^{buf_empty1, head_flag1, head_zero1, buf_out1};
  assign pop_two  = 1'b0;
  assign hz1_in   = 1'b1;
  assign s1_entry = '0;
`endif

  rob_commit_slot #(.DATA_WIDTH(DATA_WIDTH), .TAG_WIDTH(TAG_WIDTH)) u_slot0 (
    .active   (1'b1),
    .zero_hint(zero0_q),
    .entry    (buf_out0),
    .qual     (q0),
    .waddr    (a0),
    .wdata    (d0),
    .tag      (t0)
  );

  rob_commit_slot #(.DATA_WIDTH(DATA_WIDTH), .TAG_WIDTH(TAG_WIDTH)) u_slot1 (
    .active   (re_q == RE_TWO),
    .zero_hint(zero1_q),
    .entry    (s1_entry),
    .qual     (q1),
    .waddr    (a1),
    .wdata    (d1),
    .tag      (t1)
  );

  always_comb begin
    state_d     = state_q;
    re_d        = re_q;
    rd_strobe_d = 1'b0;
    flushed_d   = flushed_q;
    zero0_d     = zero0_q;
    zero1_d     = zero1_q;
    we0_d       = 1'b0;
    we1_d       = 1'b0;
    waddr0_d    = waddr0_q;
    waddr1_d    = waddr1_q;
    wdata0_d    = wdata0_q;
    wdata1_d    = wdata1_q;
    last_tag_d  = last_tag_q;
    cnt_d       = cnt_q;

    case (state_q)
      ST_IDLE: begin
        flushed_d = 1'b0;
        if (commit_en && !flush && (pop_two || pop_one)) begin
          re_d        = pop_two ? RE_TWO : RE_ONE;
          zero0_d     = head_zero0;
          zero1_d     = hz1_in;
          rd_strobe_d = 1'b1;
          state_d     = ST_STROBE;
        end
      end
      ST_STROBE: begin
        flushed_d = flushed_q | flush;
        state_d   = ST_SETTLE;
      end
      ST_SETTLE: begin
        // Write outputs are registered on entry to WRITE, so a flush seen up to
        // this edge is what cancels the group.
        state_d  = ST_WRITE;
        waddr0_d = a0;
        waddr1_d = a1;
        wdata0_d = d0;
        wdata1_d = d1;
        if (!(flushed_q || flush)) begin
          we0_d = q0 && !(q1 && (a0 == a1));
          we1_d = q1;
          cnt_d = cnt_q + 32'(we0_d) + 32'(we1_d);
          if (q1)      last_tag_d = t1;
          else if (q0) last_tag_d = t0;
        end
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      re_q        <= RE_ONE;
      rd_strobe_q <= 1'b0;
      flushed_q   <= 1'b0;
      zero0_q     <= 1'b0;
      zero1_q     <= 1'b0;
      we0_q       <= 1'b0;
      we1_q       <= 1'b0;
      waddr0_q    <= '0;
      waddr1_q    <= '0;
      wdata0_q    <= '0;
      wdata1_q    <= '0;
      last_tag_q  <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      re_q        <= re_d;
      rd_strobe_q <= rd_strobe_d;
      flushed_q   <= flushed_d;
      zero0_q     <= zero0_d;
      zero1_q     <= zero1_d;
      we0_q       <= we0_d;
      we1_q       <= we1_d;
      waddr0_q    <= waddr0_d;
      waddr1_q    <= waddr1_d;
      wdata0_q    <= wdata0_d;
      wdata1_q    <= wdata1_d;
      last_tag_q  <= last_tag_d;
      cnt_q       <= cnt_d;
    end
  end

  assign re          = re_q;
  assign rd_strobe   = rd_strobe_q;
  assign rf_we0      = we0_q;
  assign rf_we1      = we1_q;
  assign rf_waddr0   = waddr0_q;
  assign rf_waddr1   = waddr1_q;
  assign rf_wdata0   = wdata0_q;
  assign rf_wdata1   = wdata1_q;
  assign last_tag    = last_tag_q;
  assign retired_cnt = cnt_q;

endmodule
